// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, redirect flushes,
// data-memory wait handling with timeout, and saturating perf counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             exmem_jump,
    input  logic             exmem_memrd,
    input  logic             exmem_memwr,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_redirect,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic taken, lduse, memop, mem_stall;

    assign taken = (exmem_branch & exmem_zero) | exmem_jump;
    assign memop = exmem_memrd | exmem_memwr;
    assign lduse = idex_memread & (idex_rd != REG_X0) &
                   ((ifid_use_rs1 & (ifid_rs1 == idex_rd)) |
                    (ifid_use_rs2 & (ifid_rs2 == idex_rd)));

    // A ready in MEM_WAIT releases the stall in that same cycle, so the
    // frozen EX/MEM contents (including a pending redirect) act right away.
    assign mem_stall = (state_q == ERR) |
                       (((state_q == MEM_WAIT) | memop) & ~dmem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        unique case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (memop && !dmem_ready) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ERR: begin
                mem_err_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        pc_redirect  = 1'b0;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_hold   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        unique case (state_q)
            RUN:      dmem_req = memop;
            MEM_WAIT: dmem_req = 1'b1;
            default:  dmem_req = 1'b0;
        endcase

        if (reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            memwb_bubble = 1'b1;
            dmem_req     = 1'b0;
        end else if (mem_stall) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            exmem_hold   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (taken) begin
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (lduse) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign mem_err = mem_err_q;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (~pc_write),
        .count(stall_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (pc_redirect),
        .count(flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a rule-level model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MT  = 4;
    localparam int unsigned CW  = 4;
    localparam int          SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    ifid_rs1, ifid_rs2, idex_rd;
    logic          ifid_use_rs1, ifid_use_rs2, idex_memread;
    logic          exmem_branch, exmem_zero, exmem_jump, exmem_memrd, exmem_memwr;
    logic          dmem_ready;
    logic          pc_write, pc_redirect, ifid_write, ifid_flush, idex_flush;
    logic          exmem_hold, exmem_flush, memwb_bubble, dmem_req, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_bad = 0;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(MT),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ifid_rs1    (ifid_rs1),
        .ifid_rs2    (ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1),
        .ifid_use_rs2(ifid_use_rs2),
        .idex_memread(idex_memread),
        .idex_rd     (idex_rd),
        .exmem_branch(exmem_branch),
        .exmem_zero  (exmem_zero),
        .exmem_jump  (exmem_jump),
        .exmem_memrd (exmem_memrd),
        .exmem_memwr (exmem_memwr),
        .dmem_ready  (dmem_ready),
        .pc_write    (pc_write),
        .pc_redirect (pc_redirect),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_hold  (exmem_hold),
        .exmem_flush (exmem_flush),
        .memwb_bubble(memwb_bubble),
        .dmem_req    (dmem_req),
        .mem_err     (mem_err),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    logic [8:0] dut_ctrl;
    assign dut_ctrl = {pc_write, pc_redirect, ifid_write, ifid_flush, idex_flush,
                       exmem_hold, exmem_flush, memwb_bubble, dmem_req};

    // Model state: 0 = running, 1 = waiting on memory, 2 = timed out.
    int m_st    = 0;
    int m_waits = 0;
    int m_stall = 0;
    int m_flush = 0;
    bit m_err   = 1'b0;
    bit started = 1'b0;

    function automatic logic [8:0] model_ctrl();
        bit taken, lduse, memop, frozen;
        logic [8:0] c;
        if (reset) return 9'b000110110;
        taken  = (exmem_branch && exmem_zero) || exmem_jump;
        memop  = exmem_memrd || exmem_memwr;
        lduse  = idex_memread && (idex_rd != 0) &&
                 ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
        frozen = (m_st == 2) || ((m_st == 1 || memop) && !dmem_ready);
        c[0]   = (m_st == 1) ? 1'b1 : (m_st == 2) ? 1'b0 : memop;
        if (frozen)     c[8:1] = 8'b00000101;
        else if (taken) c[8:1] = 8'b11111010;
        else if (lduse) c[8:1] = 8'b00001000;
        else            c[8:1] = 8'b10100000;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model_update
        logic [8:0] c;
        c = model_ctrl();
        if (reset) begin
            m_st = 0; m_waits = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
        end else begin
            if (!c[8] && m_stall < SAT) m_stall++;
            if (c[7] && m_flush < SAT) m_flush++;
            case (m_st)
                0: if ((exmem_memrd || exmem_memwr) && !dmem_ready) begin
                    m_st = 1; m_waits = 0;
                end
                1: if (dmem_ready) m_st = 0;
                   else begin
                       m_waits++;
                       if (m_waits == MT) begin m_st = 2; m_err = 1'b1; end
                   end
                default: ;
            endcase
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("ctrl", {23'd0, dut_ctrl}, {23'd0, model_ctrl()});
            check("mem_err", {31'd0, mem_err}, {31'd0, m_err});
            check("stall_cnt", {28'd0, stall_cnt}, m_stall);
            check("flush_cnt", {28'd0, flush_cnt}, m_flush);
        end
    end

    task automatic idle();
        ifid_rs1 = 5'd1; ifid_rs2 = 5'd2; ifid_use_rs1 = 1'b0; ifid_use_rs2 = 1'b0;
        idex_memread = 1'b0; idex_rd = 5'd0;
        exmem_branch = 1'b0; exmem_zero = 1'b0; exmem_jump = 1'b0;
        exmem_memrd = 1'b0; exmem_memwr = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        #2;
        check("rst_stall_cnt", {28'd0, stall_cnt}, 0);
        check("rst_flush_cnt", {28'd0, flush_cnt}, 0);
        check("rst_mem_err", {31'd0, mem_err}, 0);
        check("idle_pc_write", {31'd0, pc_write}, 1);

        // lw x5 ; add x6,x5,x1
        idex_memread = 1'b1; idex_rd = 5'd5;
        ifid_rs1 = 5'd5; ifid_use_rs1 = 1'b1; ifid_rs2 = 5'd1; ifid_use_rs2 = 1'b1;
        #2;
        check("t1_pc_write", {31'd0, pc_write}, 0);
        check("t1_idex_flush", {31'd0, idex_flush}, 1);
        step();
        idle();
        #2;
        check("t1_stall_cnt", {28'd0, stall_cnt}, 1);

        // load to x0 never stalls
        idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_use_rs1 = 1'b1;
        #2;
        check("t2_pc_write", {31'd0, pc_write}, 1);
        step();

        // taken beq
        idle();
        exmem_branch = 1'b1; exmem_zero = 1'b1;
        #2;
        check("t3_redirect", {31'd0, pc_redirect}, 1);
        check("t3_exmem_flush", {31'd0, exmem_flush}, 1);
        step();
        exmem_zero = 1'b0;
        #2;
        check("t3_not_taken", {31'd0, pc_redirect}, 0);
        check("t3_flush_cnt", {28'd0, flush_cnt}, 1);
        step();
        // load-use together with taken: redirect wins
        exmem_zero = 1'b1; idex_memread = 1'b1; idex_rd = 5'd7;
        ifid_rs2 = 5'd7; ifid_use_rs2 = 1'b1;
        #2;
        check("t3_lduse_taken_pc", {31'd0, pc_write}, 1);
        check("t3_lduse_taken_idex", {31'd0, idex_flush}, 1);
        step();

        // store with 3 not-ready cycles
        idle();
        exmem_memwr = 1'b1; dmem_ready = 1'b0;
        step();
        step();
        #2;
        check("t4_hold", {31'd0, exmem_hold}, 1);
        check("t4_req", {31'd0, dmem_req}, 1);
        step();
        dmem_ready = 1'b1;
        #2;
        check("t4_release", {31'd0, pc_write}, 1);
        step();
        idle();
        #2;
        check("t4_stall_cnt", {28'd0, stall_cnt}, 4);

        // jump stuck behind a load; redirect only in the ready cycle
        exmem_jump = 1'b1; exmem_memrd = 1'b1; dmem_ready = 1'b0;
        #2;
        check("t6_no_redirect_a", {31'd0, pc_redirect}, 0);
        step();
        #2;
        check("t6_no_redirect_b", {31'd0, pc_redirect}, 0);
        step();
        dmem_ready = 1'b1;
        #2;
        check("t6_redirect", {31'd0, pc_redirect}, 1);
        step();
        idle();
        #2;
        check("t6_flush_cnt", {28'd0, flush_cnt}, 3);

        // saturate both counters
        idex_memread = 1'b1; idex_rd = 5'd9; ifid_rs1 = 5'd9; ifid_use_rs1 = 1'b1;
        repeat (12) step();
        idle();
        #2;
        check("sat_stall_cnt", {28'd0, stall_cnt}, SAT);
        exmem_jump = 1'b1;
        repeat (14) step();
        idle();
        #2;
        check("sat_flush_cnt", {28'd0, flush_cnt}, SAT);

        // load never completes -> timeout
        exmem_memrd = 1'b1; dmem_ready = 1'b0;
        repeat (4) step();
        #2;
        check("t5_pre_err", {31'd0, mem_err}, 0);
        step();
        exmem_jump = 1'b1;
        #2;
        check("t5_mem_err", {31'd0, mem_err}, 1);
        check("t5_err_req", {31'd0, dmem_req}, 0);
        check("t5_err_redirect", {31'd0, pc_redirect}, 0);
        reset = 1'b1;
        #2;
        check("t5_rst_req", {31'd0, dmem_req}, 0);
        step();
        reset = 1'b0;
        idle();
        #2;
        check("t5_clear_err", {31'd0, mem_err}, 0);
        check("t5_clear_stall", {28'd0, stall_cnt}, 0);

        // ready arrives on the last allowed wait cycle
        exmem_memrd = 1'b1; dmem_ready = 1'b0;
        repeat (4) step();
        dmem_ready = 1'b1;
        step();
        idle();
        #2;
        check("edge_no_err", {31'd0, mem_err}, 0);
        check("edge_stall_cnt", {28'd0, stall_cnt}, 4);
        check("edge_pc_write", {31'd0, pc_write}, 1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
